// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator: channel state
// encoding, reset-period computation and the minimum effective period.
package pulse_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Shortest period that still leaves one low cycle after a one-cycle pulse
    localparam int P_MIN = 2;

    function automatic int calc_p0(input int freq_in, input int freq_out);
        return freq_in / freq_out;
    endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// One pulse generator channel: shadow config, IDLE/RUN state machine,
// period counter and width counter driving a registered pulse output.
module pulse_gen_ch
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int P0         = 10,
    parameter bit AUTO_START = 1'b1
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    output logic             pulse,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] P0_V    = CNT_W'(P0);
    localparam logic [CNT_W-1:0] P_MIN_V = CNT_W'(P_MIN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] shd_period, shd_width;
    logic             shd_oneshot;
    logic [CNT_W-1:0] act_period, cnt, wcnt;
    logic             act_oneshot;
    logic             auto_pend;
    logic [CNT_W-1:0] shd_p_eff, shd_w_eff;
    logic             go, wrap, finish;

    // Clamped view of the shadow settings; applied at start and at every wrap
    always_comb begin
        shd_p_eff = (shd_period < P_MIN_V) ? P_MIN_V : shd_period;
        shd_w_eff = (shd_width > shd_p_eff - ONE) ? shd_p_eff - ONE : shd_width;
        go        = start | auto_pend;
        wrap      = (state == RUN) && (cnt == act_period - ONE);
        finish    = (state == RUN) && act_oneshot &&
                    ((wrap && (shd_w_eff == '0)) || (wcnt == ONE));
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (go && !stop) state_nxt = RUN;
            RUN: begin
                if (stop)                state_nxt = IDLE;
                else if (!go && finish)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // Stop beats start; start (re)loads settings; otherwise count, wrap or finish
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            shd_period  <= P0_V;
            shd_width   <= ONE;
            shd_oneshot <= 1'b0;
            act_period  <= P0_V;
            act_oneshot <= 1'b0;
            cnt         <= '0;
            wcnt        <= '0;
            pulse       <= 1'b0;
            done        <= 1'b0;
            auto_pend   <= AUTO_START;
        end else begin
            auto_pend <= 1'b0;
            done      <= 1'b0;
            if (cfg_we) begin
                shd_period  <= cfg_period;
                shd_width   <= cfg_width;
                shd_oneshot <= cfg_oneshot;
            end
            if (stop) begin
                cnt   <= '0;
                wcnt  <= '0;
                pulse <= 1'b0;
            end else if (go) begin
                cnt         <= '0;
                wcnt        <= '0;
                pulse       <= 1'b0;
                act_period  <= shd_p_eff;
                act_oneshot <= shd_oneshot;
            end else if (state == RUN) begin
                if (finish) begin
                    done  <= 1'b1;
                    cnt   <= '0;
                    wcnt  <= '0;
                    pulse <= 1'b0;
                end else if (wrap) begin
                    cnt        <= '0;
                    act_period <= shd_p_eff;
                    wcnt       <= shd_w_eff;
                    pulse      <= (shd_w_eff != '0);
                end else begin
                    cnt   <= cnt + ONE;
                    pulse <= (wcnt > ONE);
                    if (wcnt != '0) wcnt <= wcnt - ONE;
                end
            end
        end
    end

endmodule

// File: rtl/pulse_gen.sv
// Multi-channel programmable pulse generator: config address decode and
// fan-out to NUM_CH independent channels.
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int  FREQ_IN    = 1000,
    parameter int  FREQ_OUT   = 100,
    parameter int  NUM_CH     = 2,
    parameter int  CNT_W      = 16,
    parameter bit  AUTO_START = 1'b1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK_IN,
    input  logic              RST_IN,
    input  logic              CFG_WE,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [CNT_W-1:0]  CFG_PERIOD,
    input  logic [CNT_W-1:0]  CFG_WIDTH,
    input  logic              CFG_ONESHOT,
    input  logic [NUM_CH-1:0] START,
    input  logic [NUM_CH-1:0] STOP,
    output logic [NUM_CH-1:0] PULSE_OUT,
    output logic [NUM_CH-1:0] BUSY,
    output logic [NUM_CH-1:0] DONE
);

    localparam int P0 = calc_p0(FREQ_IN, FREQ_OUT);

    logic [NUM_CH-1:0] ch_we;

    // Addresses at or beyond NUM_CH select no channel
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_we[i] = CFG_WE && (int'(CFG_CH) == i);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulse_gen_ch #(
            .CNT_W      (CNT_W),
            .P0         (P0),
            .AUTO_START (AUTO_START)
        ) u_ch (
            .CLK_IN      (CLK_IN),
            .RST_IN      (RST_IN),
            .cfg_we      (ch_we[g]),
            .cfg_period  (CFG_PERIOD),
            .cfg_width   (CFG_WIDTH),
            .cfg_oneshot (CFG_ONESHOT),
            .start       (START[g]),
            .stop        (STOP[g]),
            .pulse       (PULSE_OUT[g]),
            .busy        (BUSY[g]),
            .done        (DONE[g])
        );
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed, table-driven bench for pulse_gen (two-channel auto-start DUT plus
// a three-channel DUT for out-of-range config addresses).
module tb_pulse_gen;

    logic        CLK_IN = 1'b0;
    logic        RST_IN = 1'b1;
    logic        CFG_WE = 1'b0;
    logic [0:0]  CFG_CH = '0;
    logic [15:0] CFG_PERIOD = '0;
    logic [15:0] CFG_WIDTH = '0;
    logic        CFG_ONESHOT = 1'b0;
    logic [1:0]  START = '0;
    logic [1:0]  STOP = '0;
    logic [1:0]  PULSE_OUT, BUSY, DONE;

    logic        rst3 = 1'b1;
    logic        we3 = 1'b0;
    logic [1:0]  ch3 = '0;
    logic [15:0] per3 = '0;
    logic [15:0] wid3 = '0;
    logic        os3 = 1'b0;
    logic [2:0]  start3 = '0;
    logic [2:0]  stop3 = '0;
    logic [2:0]  pulse3, busy3, done3;

    int checks = 0;
    int errors = 0;

    always #5 CLK_IN = ~CLK_IN;

    pulse_gen #(
        .FREQ_IN(1000), .FREQ_OUT(100), .NUM_CH(2), .CNT_W(16), .AUTO_START(1'b1)
    ) u_dut (
        .CLK_IN(CLK_IN), .RST_IN(RST_IN), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
        .CFG_PERIOD(CFG_PERIOD), .CFG_WIDTH(CFG_WIDTH), .CFG_ONESHOT(CFG_ONESHOT),
        .START(START), .STOP(STOP), .PULSE_OUT(PULSE_OUT), .BUSY(BUSY), .DONE(DONE)
    );

    pulse_gen #(
        .FREQ_IN(40), .FREQ_OUT(10), .NUM_CH(3), .CNT_W(16), .AUTO_START(1'b0)
    ) u_dut3 (
        .CLK_IN(CLK_IN), .RST_IN(rst3), .CFG_WE(we3), .CFG_CH(ch3),
        .CFG_PERIOD(per3), .CFG_WIDTH(wid3), .CFG_ONESHOT(os3),
        .START(start3), .STOP(stop3), .PULSE_OUT(pulse3), .BUSY(busy3), .DONE(done3)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic        ch;
        logic [15:0] per;
        logic [15:0] wid;
        logic        os;
        logic [1:0]  start;
        logic [1:0]  stop;
        logic [1:0]  ep;
        logic [1:0]  eb;
        logic [1:0]  ed;
        logic        bchk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t make_vec(input logic rst, input logic we, input logic ch,
                                      input int per, input int wid, input logic os,
                                      input logic [1:0] st, input logic [1:0] sp,
                                      input logic [1:0] ep, input logic [1:0] eb,
                                      input logic [1:0] ed, input logic bchk);
        vec_t v;
        v.rst = rst; v.we = we; v.ch = ch; v.per = 16'(per); v.wid = 16'(wid);
        v.os = os; v.start = st; v.stop = sp; v.ep = ep; v.eb = eb; v.ed = ed;
        v.bchk = bchk;
        return v;
    endfunction

    function automatic vec_t idle(input logic [1:0] ep, input logic [1:0] eb,
                                  input logic [1:0] ed);
        return make_vec(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 2'b00, 2'b00, ep, eb, ed, 1'b1);
    endfunction

    // Drive one cycle of inputs, then sample just after the edge that takes them
    task automatic applyStimulus(input vec_t v);
        RST_IN      = v.rst;
        CFG_WE      = v.we;
        CFG_CH      = v.ch;
        CFG_PERIOD  = v.per;
        CFG_WIDTH   = v.wid;
        CFG_ONESHOT = v.os;
        START       = v.start;
        STOP        = v.stop;
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        // Channel 1 periodic P=8 W=3, then restart mid-pulse, then START+STOP
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1));
        vecs.push_back(make_vec(0, 1, 1, 8, 3, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 0));
        for (int e = 1; e <= 24; e++)
            vecs.push_back(idle(((e >= 8 && e <= 10) || (e >= 16 && e <= 18) || e == 24)
                                ? 2'b10 : 2'b00, 2'b10, 2'b00));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1));
        for (int e = 1; e <= 8; e++)
            vecs.push_back(idle((e == 8) ? 2'b10 : 2'b00, 2'b10, 2'b00));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1));
        vecs.push_back(idle(2'b00, 2'b00, 2'b00));

        // Channel 0 one-shot P=5 W=2
        vecs.push_back(make_vec(0, 1, 0, 5, 2, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0));
        for (int e = 1; e <= 10; e++)
            vecs.push_back(idle((e == 5 || e == 6) ? 2'b01 : 2'b00,
                                (e <= 6) ? 2'b01 : 2'b00,
                                (e == 7) ? 2'b01 : 2'b00));

        // Clamping: P=1 W=9 periodic on ch1 alternates high/low
        vecs.push_back(make_vec(0, 1, 1, 1, 9, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 0));
        for (int e = 1; e <= 8; e++)
            vecs.push_back(idle((e % 2 == 0) ? 2'b10 : 2'b00, 2'b10, 2'b00));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1));

        // Clamping: P=1 W=0 one-shot on ch0 never pulses, DONE after 2 cycles
        vecs.push_back(make_vec(0, 1, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0));
        vecs.push_back(idle(2'b00, 2'b01, 2'b00));
        vecs.push_back(idle(2'b00, 2'b00, 2'b01));
        vecs.push_back(idle(2'b00, 2'b00, 2'b00));

        // Mid-run write of P=4 to ch0 running with P=10
        vecs.push_back(make_vec(0, 1, 0, 10, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 0));
        vecs.push_back(idle(2'b00, 2'b01, 2'b00));
        vecs.push_back(idle(2'b00, 2'b01, 2'b00));
        vecs.push_back(make_vec(0, 1, 0, 4, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1));
        for (int e = 4; e <= 22; e++)
            vecs.push_back(idle((e == 10 || e == 14 || e == 18 || e == 22) ? 2'b01 : 2'b00,
                                2'b01, 2'b00));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1));

        // Reset in the middle of a 4-wide pulse, then auto-restart at defaults
        vecs.push_back(make_vec(0, 1, 1, 6, 4, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 0));
        for (int e = 1; e <= 6; e++)
            vecs.push_back(idle((e == 6) ? 2'b10 : 2'b00, 2'b10, 2'b00));
        vecs.push_back(make_vec(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));
        vecs.push_back(make_vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 0));
        for (int e = 1; e <= 10; e++)
            vecs.push_back(idle((e == 10) ? 2'b11 : 2'b00, 2'b11, 2'b00));

        // Reset with auto-start: legacy 1-in-10 divider behaviour on both channels
        repeat (2) @(posedge CLK_IN);
        #1;
        checkOutput("reset pulse", {1'b0, PULSE_OUT}, 3'b000);
        checkOutput("reset busy", {1'b0, BUSY}, 3'b000);
        checkOutput("reset done", {1'b0, DONE}, 3'b000);
        RST_IN = 1'b0;
        for (int k = 0; k <= 21; k++) begin
            @(posedge CLK_IN);
            #1;
            checkOutput($sformatf("auto pulse E%0d", k), {1'b0, PULSE_OUT},
                        (k == 10 || k == 20) ? 3'b011 : 3'b000);
            checkOutput($sformatf("auto done E%0d", k), {1'b0, DONE}, 3'b000);
            if (k >= 1) checkOutput($sformatf("auto busy E%0d", k), {1'b0, BUSY}, 3'b011);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d pulse", i), {1'b0, PULSE_OUT}, {1'b0, vecs[i].ep});
            checkOutput($sformatf("vec%0d done", i), {1'b0, DONE}, {1'b0, vecs[i].ed});
            if (vecs[i].bchk)
                checkOutput($sformatf("vec%0d busy", i), {1'b0, BUSY}, {1'b0, vecs[i].eb});
        end

        // Three-channel DUT: no auto-start, write to CFG_CH=3 must be ignored
        checkOutput("dut3 reset busy", busy3, 3'b000);
        checkOutput("dut3 reset pulse", pulse3, 3'b000);
        rst3 = 1'b0;
        @(posedge CLK_IN);
        #1;
        checkOutput("dut3 no autostart", busy3, 3'b000);
        we3 = 1'b1; ch3 = 2'd3; per3 = 16'd2; wid3 = 16'd1;
        @(posedge CLK_IN);
        #1;
        ch3 = 2'd2; per3 = 16'd6;
        @(posedge CLK_IN);
        #1;
        we3 = 1'b0; start3 = 3'b111;
        @(posedge CLK_IN);
        #1;
        start3 = 3'b000;
        for (int e = 1; e <= 6; e++) begin
            @(posedge CLK_IN);
            #1;
            checkOutput($sformatf("dut3 pulse E%0d", e), pulse3,
                        (e == 4) ? 3'b011 : ((e == 6) ? 3'b100 : 3'b000));
            if (e == 1) checkOutput("dut3 busy", busy3, 3'b111);
        end
        checkOutput("dut3 done", done3, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
